// File: rtl/cfg_loader.sv
// cfg_loader: parses 0xA5/index/payload/checksum byte frames into per-channel
// configuration registers and answers each complete frame with ACK or NAK.
module cfg_loader #(
  parameter int CH_NO       = 4,
  parameter int CONF_BITS   = 80,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic [CH_NO*CONF_BITS-1:0] ch_conf,
  output logic [CH_NO-1:0]           conf_upd,
  output logic [7:0]                 resp_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [7:0]                 err_cnt,
  output logic                       resp_ovr
);
  localparam int CONF_BYTES = CONF_BITS / 8;
  localparam int CW = $clog2(CONF_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, INDEX, PAYLOAD, CHECK} state_t;
  state_t               r_state;
  logic [7:0]           r_idx;
  logic [7:0]           r_xor;
  logic [CW-1:0]        r_cnt;
  logic [TW-1:0]        r_timer;
  logic [CONF_BITS-1:0] r_stage;
  logic [CH_NO-1:0]     w_hit;
  logic                 w_load;
  logic                 w_good;
  logic                 w_tmo;
  always_comb begin
    for (int c = 0; c < CH_NO; c++) w_hit[c] = r_idx == 8'(c);
    w_load = in_valid && r_state == CHECK;
    w_good = in_data == r_xor && |w_hit;
    w_tmo  = r_state != IDLE && !in_valid && r_timer == TW'(TIMEOUT_CYC - 1);
  end
  // Payload shifts in from the top so byte 0 lands in bits [7:0] once the frame is complete.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_xor      <= '0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_stage    <= '0;
      ch_conf    <= '0;
      conf_upd   <= '0;
      resp_data  <= 8'h00;
      resp_valid <= 1'b0;
      resp_ovr   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      conf_upd <= '0;
      r_timer  <= (r_state == IDLE || in_valid || w_tmo) ? '0 : r_timer + 1'b1;
      if (w_tmo) begin
        r_state <= IDLE;
        err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 1'b1;
      end
      if (in_valid) begin
        case (r_state)
          IDLE: r_state <= (in_data == 8'hA5) ? INDEX : IDLE;
          INDEX: begin
            r_idx   <= in_data;
            r_xor   <= in_data;
            r_cnt   <= '0;
            r_state <= PAYLOAD;
          end
          PAYLOAD: begin
            r_stage <= {in_data, r_stage[CONF_BITS-1:8]};
            r_xor   <= r_xor ^ in_data;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= (r_cnt == CW'(CONF_BYTES - 1)) ? CHECK : PAYLOAD;
          end
          CHECK: begin
            r_state <= IDLE;
            if (w_good) begin
              for (int c = 0; c < CH_NO; c++)
                if (w_hit[c]) ch_conf[c*CONF_BITS +: CONF_BITS] <= r_stage;
              conf_upd <= w_hit;
            end else begin
              err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      // A fresh response always wins; it only counts as an overwrite if the old one was not taken.
      if (w_load) begin
        resp_data  <= w_good ? 8'h06 : 8'h15;
        resp_valid <= 1'b1;
        if (resp_valid && !resp_ready) resp_ovr <= 1'b1;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end
endmodule
